// File: rtl/mc_fifo_pkg.sv
// Shared types and helpers for the memory-controller flit FIFO.
// Holds the default flit width, the read-mode encoding and the pointer width.
package mc_fifo_pkg;

   localparam int unsigned FLIT_WIDTH = 637;

   typedef enum logic {
      ModeNormal,
      ModeShowAhead
   } read_mode_e;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/mc_fifo_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module mc_fifo_ram
   import mc_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = FLIT_WIDTH,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = ptr_width(DEPTH)
) (
   input  logic             clock_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clock_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mc_fifo_sync.sv
// Single-clock flit FIFO with fill count, threshold flags, normal or show-ahead
// read mode, synchronous clear and registered overflow/underflow pulses.
module mc_fifo_sync
   import mc_fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = FLIT_WIDTH,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned SHOWAHEAD = 0,
   parameter int unsigned AF_THRESH = DEPTH - 2,
   parameter int unsigned AE_THRESH = 2,
   localparam int unsigned PW       = ptr_width(DEPTH),
   localparam int unsigned UW       = PW + 1
) (
   input  logic             clock,
   input  logic             aclr,
   input  logic             sclr,
   input  logic [WIDTH-1:0] data,
   input  logic             wrreq,
   input  logic             rdreq,
   output logic [WIDTH-1:0] q,
   output logic             empty,
   output logic             full,
   output logic             almost_empty,
   output logic             almost_full,
   output logic [UW-1:0]    usedw,
   output logic             overflow,
   output logic             underflow
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("mc_fifo_sync: DEPTH must be a power of two and at least 2");
   end
   if (AF_THRESH == 0 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("mc_fifo_sync: AF_THRESH must be in 1..DEPTH");
   end
   if (AE_THRESH > DEPTH) begin : g_bad_ae
      $error("mc_fifo_sync: AE_THRESH must be in 0..DEPTH");
   end

   localparam read_mode_e     Mode   = (SHOWAHEAD != 0) ? ModeShowAhead : ModeNormal;
   localparam logic [UW-1:0] DepthU = UW'(DEPTH);
   localparam logic [UW-1:0] AfU    = UW'(AF_THRESH);
   localparam logic [UW-1:0] AeU    = UW'(AE_THRESH);
   localparam logic          AeRst  = (AE_THRESH > 0);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [UW-1:0]    usedw_q, usedw_d;
   logic             empty_q, empty_d, full_q, full_d;
   logic             ae_q, ae_d, af_q, af_d;
   logic             ovf_q, ovf_d, udf_q, udf_d;
   logic [WIDTH-1:0] q_q, q_d, ram_rdata;
   logic             rd_acc, wr_acc, ram_we;

   always_comb begin
      rd_acc   = rdreq & ~empty_q;
      wr_acc   = wrreq & (~full_q | rd_acc);
      wr_ptr_d = wr_ptr_q + PW'(wr_acc);
      rd_ptr_d = rd_ptr_q + PW'(rd_acc);
      usedw_d  = usedw_q + UW'(wr_acc) - UW'(rd_acc);
      q_d      = q_q;
      if (Mode == ModeNormal && rd_acc) begin
         q_d = ram_rdata;
      end
      ovf_d  = wrreq & ~wr_acc;
      udf_d  = rdreq & empty_q;
      ram_we = wr_acc & ~sclr;
      if (sclr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         usedw_d  = '0;
         q_d      = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end
      // Flags come from the next count so they line up with usedw.
      empty_d = (usedw_d == '0);
      full_d  = (usedw_d == DepthU);
      af_d    = (usedw_d >= AfU);
      ae_d    = (usedw_d < AeU);
   end

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         usedw_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         ae_q     <= AeRst;
         af_q     <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         q_q      <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         usedw_q  <= usedw_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         ae_q     <= ae_d;
         af_q     <= af_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         q_q      <= q_d;
      end
   end

   mc_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_ram (
      .clock_i (clock),
      .we_i    (ram_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (data),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata)
   );

   assign q            = (Mode == ModeShowAhead) ? ram_rdata : q_q;
   assign empty        = empty_q;
   assign full         = full_q;
   assign almost_empty = ae_q;
   assign almost_full  = af_q;
   assign usedw        = usedw_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule

// File: tb/tb_mc_fifo_sync.sv
// Directed bench: three FIFO instances (depth 4 normal, depth 4 show-ahead,
// depth 16 wide) share stimulus; each phase clears them and checks one.
module tb_mc_fifo_sync;

   logic         clock = 1'b0;
   logic         aclr, sclr, wrreq, rdreq;
   logic [7:0]   data;

   logic [7:0]   a_q, s_q;
   logic [636:0] d_q;
   logic [2:0]   a_uw, s_uw;
   logic [4:0]   d_uw;
   logic a_empty, a_full, a_ae, a_af, a_ovf, a_udf;
   logic s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
   logic d_empty, d_full, d_ae, d_af, d_ovf, d_udf;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clock = ~clock;

   mc_fifo_sync #(.WIDTH(8), .DEPTH(4), .SHOWAHEAD(0)) dut_a (
      .clock (clock), .aclr (aclr), .sclr (sclr), .data (data),
      .wrreq (wrreq), .rdreq (rdreq), .q (a_q), .empty (a_empty), .full (a_full),
      .almost_empty (a_ae), .almost_full (a_af), .usedw (a_uw),
      .overflow (a_ovf), .underflow (a_udf)
   );

   mc_fifo_sync #(.WIDTH(8), .DEPTH(4), .SHOWAHEAD(1)) dut_s (
      .clock (clock), .aclr (aclr), .sclr (sclr), .data (data),
      .wrreq (wrreq), .rdreq (rdreq), .q (s_q), .empty (s_empty), .full (s_full),
      .almost_empty (s_ae), .almost_full (s_af), .usedw (s_uw),
      .overflow (s_ovf), .underflow (s_udf)
   );

   mc_fifo_sync #(.DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut_d (
      .clock (clock), .aclr (aclr), .sclr (sclr), .data ({629'b0, data}),
      .wrreq (wrreq), .rdreq (rdreq), .q (d_q), .empty (d_empty), .full (d_full),
      .almost_empty (d_ae), .almost_full (d_af), .usedw (d_uw),
      .overflow (d_ovf), .underflow (d_udf)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_aclr();
      aclr = 1'b1;
      #1;
      aclr = 1'b0;
   endtask

   logic [7:0] wrap_exp [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'h12, 8'h13};
   logic [7:0] abcd     [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

   initial begin
      aclr = 1'b1; sclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = 8'h00;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_empty", 64'(a_empty), 64'd1);
      chk("rst_full",  64'(a_full),  64'd0);
      chk("rst_usedw", 64'(a_uw),    64'd0);
      chk("rst_q",     64'(a_q),     64'd0);
      chk("rst_ae",    64'(a_ae),    64'd1);
      chk("rst_af",    64'(a_af),    64'd0);
      chk("rst_ovf",   64'(a_ovf),   64'd0);
      chk("rst_udf",   64'(a_udf),   64'd0);
      aclr = 1'b0;

      // Depth 4 normal mode: fill, overflow, drain in order.
      wrreq = 1'b1;
      for (int i = 0; i < 4; i++) begin
         data = abcd[i];
         step();
         chk("fill_usedw", 64'(a_uw), 64'(i + 1));
      end
      chk("fill_full", 64'(a_full), 64'd1);
      chk("fill_af",   64'(a_af),   64'd1);
      data = 8'hEE;
      step();
      chk("ovf_pulse", 64'(a_ovf), 64'd1);
      chk("ovf_usedw", 64'(a_uw),  64'd4);
      wrreq = 1'b0;
      step();
      chk("ovf_clear", 64'(a_ovf), 64'd0);
      rdreq = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("drain_q",     64'(a_q),  64'(abcd[i]));
         chk("drain_usedw", 64'(a_uw), 64'(3 - i));
      end
      chk("drain_empty", 64'(a_empty), 64'd1);
      chk("drain_udf",   64'(a_udf),   64'd0);

      // Underflow on the empty FIFO; q holds the last value read.
      step();
      chk("udf_pulse", 64'(a_udf), 64'd1);
      chk("udf_usedw", 64'(a_uw),  64'd0);
      chk("udf_q",     64'(a_q),   64'hD4);
      rdreq = 1'b0;
      step();
      chk("udf_clear", 64'(a_udf), 64'd0);

      // Full with simultaneous read/write across the pointer wrap.
      wrreq = 1'b1;
      for (int i = 0; i < 4; i++) begin
         data = 8'(i + 1);
         step();
      end
      rdreq = 1'b1;
      for (int i = 0; i < 8; i++) begin
         data = 8'(8'h10 + i);
         step();
         chk("wrap_q",     64'(a_q),    64'(wrap_exp[i]));
         chk("wrap_usedw", 64'(a_uw),   64'd4);
         chk("wrap_full",  64'(a_full), 64'd1);
         chk("wrap_ovf",   64'(a_ovf),  64'd0);
      end
      wrreq = 1'b0; rdreq = 1'b0;

      // Show-ahead: first word falls through with one cycle latency.
      pulse_aclr();
      step();
      chk("sa_rst_empty", 64'(s_empty), 64'd1);
      wrreq = 1'b1; data = 8'hAA;
      step();
      wrreq = 1'b0;
      chk("sa_empty", 64'(s_empty), 64'd0);
      chk("sa_q",     64'(s_q),     64'hAA);
      rdreq = 1'b1;
      step();
      rdreq = 1'b0;
      chk("sa_pop_empty", 64'(s_empty), 64'd1);
      chk("sa_pop_udf",   64'(s_udf),   64'd0);

      // Depth 16 thresholds on fill and drain.
      pulse_aclr();
      wrreq = 1'b1;
      for (int i = 0; i < 16; i++) begin
         data = 8'(i + 1);
         step();
         chk("d_fill_usedw", 64'(d_uw), 64'(i + 1));
         chk("d_fill_ae",    64'(d_ae), 64'((i + 1) < 2));
         chk("d_fill_af",    64'(d_af), 64'((i + 1) >= 14));
      end
      chk("d_full", 64'(d_full), 64'd1);
      wrreq = 1'b0; rdreq = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         chk("d_drain_q",     d_q[63:0],  64'(i + 1));
         chk("d_drain_usedw", 64'(d_uw),  64'(15 - i));
         chk("d_drain_ae",    64'(d_ae),  64'((15 - i) < 2));
         chk("d_drain_af",    64'(d_af),  64'((15 - i) >= 14));
      end
      chk("d_drain_upper", d_q[636:64] == '0 ? 64'd0 : 64'd1, 64'd0);
      rdreq = 1'b0;

      // Asynchronous clear mid-cycle with q holding data.
      pulse_aclr();
      wrreq = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data = 8'(8'h30 + i);
         step();
      end
      wrreq = 1'b0; rdreq = 1'b1;
      step();
      rdreq = 1'b0;
      chk("pre_aclr_q", 64'(a_q), 64'h30);
      #3;
      aclr = 1'b1;
      #1;
      chk("aclr_empty", 64'(a_empty), 64'd1);
      chk("aclr_usedw", 64'(a_uw),    64'd0);
      chk("aclr_q",     64'(a_q),     64'd0);
      aclr = 1'b0;

      // Synchronous clear beats a same-cycle write.
      wrreq = 1'b1; data = 8'h55;
      step();
      step();
      chk("pre_sclr_usedw", 64'(a_uw), 64'd2);
      sclr = 1'b1; data = 8'h66;
      step();
      sclr = 1'b0; wrreq = 1'b0;
      chk("sclr_usedw", 64'(a_uw),    64'd0);
      chk("sclr_empty", 64'(a_empty), 64'd1);
      chk("sclr_ae",    64'(a_ae),    64'd1);
      step();
      chk("sclr_dropped", 64'(a_uw), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mc_fifo_sync.md
Name: mc_fifo_sync

Overview:
- Parametrised single-clock FIFO for buffering memory-controller request/response flits (default 637-bit) between pipeline stages in the CXL/RDMA datapath.
- Successor to the one-entry mailbox FIFO: configurable depth, fill-level count, almost-full/almost-empty thresholds, normal or show-ahead read mode, synchronous clear and overflow/underflow error pulses.

Parameters:
- WIDTH, 637, data bits per entry.
- DEPTH, 16, number of entries; power of two, minimum 2.
- SHOWAHEAD, 0, 0 = normal read (q registered one cycle after rdreq); 1 = head entry presented on q while not empty.
- AF_THRESH, DEPTH-2, almost_full asserts when usedw >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when usedw < AE_THRESH.

Ports:
- clock  in  1  single clock; all logic on posedge.
- aclr  in  1  reset is asynchronous and active-high.
- sclr  in  1  synchronous clear; same effect as aclr, applied at the clock edge.
- data  in  WIDTH  write data.
- wrreq  in  1  write request.
- rdreq  in  1  read request (ack in show-ahead mode).
- q  out  WIDTH  read data.
- empty  out  1  no entries stored.
- full  out  1  DEPTH entries stored.
- almost_empty  out  1  usedw < AE_THRESH.
- almost_full  out  1  usedw >= AF_THRESH.
- usedw  out  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
- overflow  out  1  one-cycle pulse on a rejected write.
- underflow  out  1  one-cycle pulse on a rejected read.

Behaviour:
- Reset (aclr high, or sclr high at an edge) clears these outputs and state:
  - pointers = 0, usedw = 0, empty = 1, full = 0, almost_full = 0, q = 0, overflow = 0, underflow = 0.
  - almost_empty = (AE_THRESH > 0).
  - Storage contents are not cleared.
- aclr mid-operation discards all entries immediately.
- sclr has priority over wrreq and rdreq in the same cycle.
- rd_acc = rdreq & !empty.
- wr_acc = wrreq & (!full | rd_acc): a write to a full FIFO is accepted only when a read is accepted in the same cycle.
- Simultaneous rd_acc and wr_acc: usedw unchanged, both pointers advance.
- Empty FIFO with wrreq and rdreq together: the read is rejected (underflow pulse) and the write is accepted.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- usedw updates as +wr_acc -rd_acc at the edge.
- All flags are registered and derived from the next usedw, so they are valid the same cycle as usedw:
  - full = (usedw == DEPTH), empty = (usedw == 0).
- Normal mode:
  - On rd_acc, q loads mem[rd_ptr] at that edge; data is visible the cycle after rdreq (latency 1).
  - q holds its value otherwise.
- Show-ahead mode:
  - q = mem[rd_ptr] combinationally whenever !empty; rdreq pops and advances to the next entry.
  - First-word fall-through latency is 1 cycle from the write edge to empty deasserting with q valid.
  - q is don't-care while empty.
- overflow = wrreq & !wr_acc; underflow = rdreq & empty. Both are registered one-cycle pulses.
- Rejected operations change no state.
- Storage write occurs on wr_acc at mem[wr_ptr].
- Read-during-write to the same address returns old data; this is only reachable when full with simultaneous read and write, where the read address holds the valid oldest entry.
- Elaboration-time assertions:
  - DEPTH is a power of two and >= 2.
  - 0 < AF_THRESH <= DEPTH.
  - 0 <= AE_THRESH <= DEPTH.

Decomposition:
- Shared package mc_fifo_pkg:
  - localparam function for pointer width from DEPTH.
  - Default flit width constant 637.
  - Read-mode enum (NORMAL, SHOWAHEAD).
- One sub-module, mc_fifo_ram: simple dual-port WIDTH x DEPTH array.
  - Synchronous write.
  - Asynchronous read port, registered in the top for normal mode.
- Pointer, counter and flag logic stays in mc_fifo_sync.

Test Plan:
- DEPTH=4, normal mode: write A,B,C,D then wrreq once more -> full=1, usedw=4, overflow pulses once, and the fifth write is dropped. Reading 4 times returns A,B,C,D each one cycle after rdreq; empty=1 after the last read.
- Empty FIFO, rdreq for 1 cycle -> underflow=1 for exactly 1 cycle, usedw stays 0, q unchanged.
- Full DEPTH=4, wrreq and rdreq together for 8 cycles with data 0x10..0x17 -> no overflow, usedw stays 4, full stays 1, outputs continue in order across the pointer wrap.
- SHOWAHEAD=1: write 0xAA -> next cycle empty=0 and q=0xAA with no rdreq; rdreq -> empty=1.
- DEPTH=16, AF_THRESH=14, AE_THRESH=2: fill one entry per cycle -> almost_empty deasserts at usedw=2 and almost_full asserts at usedw=14; draining reverses both at the same counts.
- After 3 writes, assert aclr asynchronously mid-cycle -> empty=1, usedw=0, q=0 immediately. Repeat with sclr together with wrreq -> cleared and the write discarded.
